// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t          : sequencer FSM states
//   DEF_*            : default timing counts (50 MHz reference clock)
//   count_width()    : bits needed for a counter that runs 0 .. n-1
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    PERIPH_UP,
    RUN
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_CORE_DELAY         = 64;
  localparam int unsigned DEF_CNT_W              = 16;

  // A counter expiring at n-1 needs enough bits to represent n-1.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
//   i_clk     : destination clock
//   i_reset_n : synchronous active-low reset, clears the chain to 0
//   i_async   : asynchronous input level
//   o_sync    : input delayed by STAGES destination clock cycles
module reset_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer, clocked from the free-running reference clock.
// Pulses the PLL reset, waits for a stable lock, then releases peripheral
// reset followed (after CORE_DELAY) by core reset. Lock loss, lock timeout
// or a software request re-asserts resets immediately.
//   clk             : 50 MHz reference clock
//   reset_n         : synchronous active-low reset
//   pll_locked      : PLL lock flag (asynchronous)
//   sw_reset_req    : single-cycle restart request (synchronous)
//   pll_rst         : active-high PLL reset
//   periph_reset_n  : active-low peripheral reset
//   core_reset_n    : active-low core reset
//   sys_ready       : high only in RUN
//   retry_count     : saturating count of lock-timeout PLL resets
//   lost_lock_count : saturating count of lock losses after release
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned CORE_DELAY         = DEF_CORE_DELAY,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       periph_reset_n,
  output logic       core_reset_n,
  output logic       sys_ready,
  output logic [7:0] retry_count,
  output logic [7:0] lost_lock_count
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (CNT_W < count_width(max3(LOCK_TIMEOUT, LOCK_STABLE_CYCLES,
                               max3(CORE_DELAY, PLL_RST_CYCLES, 1)))) begin : g_bad_cnt
    $error("CNT_W too narrow for the configured counts");
  end

  localparam logic [CNT_W-1:0] L_PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CORE_LAST    = CNT_W'(CORE_DELAY - 1);

  logic             w_locked_s;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retry_inc;
  logic             w_lost_inc;

  reset_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_async   (pll_locked),
    .o_sync    (w_locked_s)
  );

  // Next-state decode. Priority: software request, then lock loss, then
  // counter expiry.
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_lost_inc  = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == L_PLL_RST_LAST) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (sw_reset_req) begin
          w_next = PLL_RST;
        end else if (w_locked_s) begin
          w_next = STABLE;
        end else if (r_cnt == L_TIMEOUT_LAST) begin
          w_next      = PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (sw_reset_req) begin
          w_next = PLL_RST;
        end else if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (r_cnt == L_STABLE_LAST) begin
          w_next = PERIPH_UP;
        end
      end
      PERIPH_UP: begin
        if (sw_reset_req) begin
          w_next = PLL_RST;
        end else if (!w_locked_s) begin
          w_next     = WAIT_LOCK;
          w_lost_inc = 1'b1;
        end else if (r_cnt == L_CORE_LAST) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (sw_reset_req) begin
          w_next = PLL_RST;
        end else if (!w_locked_s) begin
          w_next     = WAIT_LOCK;
          w_lost_inc = 1'b1;
        end
      end
      default: w_next = PLL_RST;
    endcase
  end

  // State, counter and outputs share one register stage; outputs are decoded
  // from w_next so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= PLL_RST;
      r_cnt           <= '0;
      pll_rst         <= 1'b1;
      periph_reset_n  <= 1'b0;
      core_reset_n    <= 1'b0;
      sys_ready       <= 1'b0;
      retry_count     <= '0;
      lost_lock_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state != RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      pll_rst        <= (w_next == PLL_RST);
      periph_reset_n <= (w_next == PERIPH_UP) || (w_next == RUN);
      core_reset_n   <= (w_next == RUN);
      sys_ready      <= (w_next == RUN);

      if (w_retry_inc && (retry_count != '1)) begin
        retry_count <= retry_count + 8'd1;
      end
      if (w_lost_inc && (lost_lock_count != '1)) begin
        lost_lock_count <= lost_lock_count + 8'd1;
      end
    end
  end

endmodule
